pwm_multichannel_gen: RTL

Parametrised N-channel PWM generator; successor to the single-channel button-driven PWM.
- Per-channel duty registers, adjusted either by debounced increase/decrease buttons or by a direct load port.
- Shared prescaled period counter with left-aligned or center-aligned mode.
- Duty changes are shadowed to period boundaries, so outputs never glitch.
- Sits behind the top-level tile wrapper; button pins come from ui_in, PWM outputs drive uo_out.

---
 rtl/pwm_multichannel_gen_if.sv | 13 +
 rtl/pwm_multichannel_gen.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_multichannel_gen_if.sv
// Duty load / readback bus of pwm_multichannel_gen: direct duty writes in, pending duties out.
interface pwm_multichannel_gen_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
);
    logic                      load_en;
    logic [2:0]                load_ch;
    logic [WIDTH-1:0]          load_val;
    logic [CHANNELS*WIDTH-1:0] duty_flat;

    modport master (output load_en, load_ch, load_val, input duty_flat);
    modport slave  (input load_en, load_ch, load_val, output duty_flat);
endinterface

// File: rtl/pwm_multichannel_gen.sv
// N-channel PWM with debounced duty buttons, shadowed duty and left/center-aligned counter.
// Optional `define PWM_PHASE_STAGGER_EN staggers left-aligned channel phases by 2^WIDTH/CHANNELS.

module pwm_btn_deb #(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic evt
);
    localparam int DW = $clog2(DEBOUNCE + 1);

    logic          s1, s2, s2_d, acc, acc_d;
    logic [DW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            {s1, s2, s2_d, acc, acc_d} <= '0;
            cnt <= '0;
        end else begin
            s1    <= btn;
            s2    <= s1;
            s2_d  <= s2;
            acc_d <= acc;
            // any edge of the synchronised level restarts the stability count
            if (s2 != s2_d)                cnt <= '0;
            else if (cnt != DW'(DEBOUNCE)) cnt <= cnt + 1'b1;
            else                           acc <= s2_d;
        end
    end

    assign evt = acc & ~acc_d;
endmodule

module pwm_channel #(
    parameter int WIDTH      = 8,
    parameter int STEP       = 16,
    parameter int DEBOUNCE   = 4,
    parameter int DUTY_RESET = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_inc,
    input  logic             btn_dec,
    input  logic             load_hit,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] cmp,
    input  logic             capture,
    input  logic             run,
    output logic [WIDTH-1:0] pending,
    output logic             pwm
);
    logic             evt_inc, evt_dec;
    logic [WIDTH-1:0] active;
    logic [WIDTH:0]   up, dn;

    pwm_btn_deb #(.DEBOUNCE(DEBOUNCE)) u_inc (.clk(clk), .rst(rst), .btn(btn_inc), .evt(evt_inc));
    pwm_btn_deb #(.DEBOUNCE(DEBOUNCE)) u_dec (.clk(clk), .rst(rst), .btn(btn_dec), .evt(evt_dec));

    // top bit is carry on increment, borrow on decrement
    assign up = {1'b0, pending} + (WIDTH+1)'(STEP);
    assign dn = {1'b0, pending} - (WIDTH+1)'(STEP);

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= WIDTH'(DUTY_RESET);
            active  <= WIDTH'(DUTY_RESET);
            pwm     <= 1'b0;
        end else begin
            if (load_hit)                 pending <= load_val;
            else if (evt_inc && !evt_dec) pending <= up[WIDTH] ? '1 : up[WIDTH-1:0];
            else if (evt_dec && !evt_inc) pending <= dn[WIDTH] ? '0 : dn[WIDTH-1:0];
            if (capture) active <= pending;
            pwm <= run && (cmp < active);
        end
    end
endmodule

module pwm_multichannel_gen #(
    parameter int CHANNELS   = 4,
    parameter int WIDTH      = 8,
    parameter int PRESCALE   = 1,
    parameter int STEP       = 16,
    parameter int DEBOUNCE   = 4,
    parameter int DUTY_RESET = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] btn_inc,
    input  logic [CHANNELS-1:0] btn_dec,
    input  logic                center_mode,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_start,
    pwm_multichannel_gen_if.slave bus
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    // S_INIT waits for the first tick after reset, which opens the first period
    typedef enum logic [1:0] {S_INIT, S_UP, S_DOWN} state_t;

    state_t                             state, state_nxt;
    logic [WIDTH-1:0]                   cnt, cnt_nxt;
    logic                               mode, mode_nxt;
    logic                               start;
    logic [PW-1:0]                      presc;
    logic                               tick;
    logic [CHANNELS-1:0][WIDTH-1:0]     pend;

    assign tick = (presc == PW'(PRESCALE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            presc        <= '0;
            state        <= S_INIT;
            cnt          <= '0;
            mode         <= 1'b0;
            period_start <= 1'b0;
        end else begin
            presc        <= tick ? '0 : presc + 1'b1;
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            mode         <= mode_nxt;
            period_start <= start;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mode_nxt  = mode;
        start     = 1'b0;
        if (tick) begin
            case (state)
                S_INIT: begin
                    start     = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = S_UP;
                end
                S_UP: begin
                    if (!mode) begin
                        cnt_nxt = cnt + 1'b1;
                        start   = (cnt == '1);
                    end else if (cnt == '1) begin
                        cnt_nxt   = cnt - 1'b1;
                        state_nxt = S_DOWN;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                S_DOWN: begin
                    cnt_nxt = cnt - 1'b1;
                    if (cnt == WIDTH'(1)) begin
                        start     = 1'b1;
                        state_nxt = S_UP;
                    end
                end
                default: state_nxt = S_INIT;
            endcase
            if (start) mode_nxt = center_mode;
        end
    end

`ifdef PWM_PHASE_STAGGER_EN
    localparam int OFS = (1 << WIDTH) / CHANNELS;
`endif

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [WIDTH-1:0] cmp;
`ifdef PWM_PHASE_STAGGER_EN
        assign cmp = mode ? cnt : cnt + WIDTH'(k * OFS);
`else
        assign cmp = cnt;
`endif
        pwm_channel #(
            .WIDTH(WIDTH), .STEP(STEP), .DEBOUNCE(DEBOUNCE), .DUTY_RESET(DUTY_RESET)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .btn_inc  (btn_inc[k]),
            .btn_dec  (btn_dec[k]),
            .load_hit (bus.load_en && (bus.load_ch == 3'(k))),
            .load_val (bus.load_val),
            .cmp      (cmp),
            .capture  (start),
            .run      (state != S_INIT),
            .pending  (pend[k]),
            .pwm      (pwm_out[k])
        );
    end

    assign bus.duty_flat = pend;
endmodule
